// File: rtl/csr_file_zicsr_if.sv
// Zicsr access bus between the execute stage and the CSR file.
// master: pipeline side (drives the request, samples the results).
// slave : CSR file side.
// Signals:
//   csr_en, csr_op[1:0], csr_addr[11:0], csr_wsrc[XLEN], csr_wsrc_zero, instret_inc  (master -> slave)
//   csr_rdata[XLEN], csr_illegal, tohost[XLEN], tohost_valid                          (slave -> master)
interface csr_file_zicsr_if #(
  parameter int unsigned XLEN = 32
);
  logic            csr_en;
  logic [1:0]      csr_op;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wsrc;
  logic            csr_wsrc_zero;
  logic            instret_inc;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_illegal;
  logic [XLEN-1:0] tohost;
  logic            tohost_valid;

  modport master (
    output csr_en, csr_op, csr_addr, csr_wsrc, csr_wsrc_zero, instret_inc,
    input  csr_rdata, csr_illegal, tohost, tohost_valid
  );

  modport slave (
    input  csr_en, csr_op, csr_addr, csr_wsrc, csr_wsrc_zero, instret_inc,
    output csr_rdata, csr_illegal, tohost, tohost_valid
  );
endinterface

// File: rtl/csr_file_zicsr.sv
// Machine-mode CSR file executing Zicsr read-modify-write ops in one cycle.
// Holds tohost, mscratch (0x340) and a constant mhartid (0xF14).
// Optional macro CSR_COUNTERS_EN adds 64-bit mcycle/minstret plus the
// read-only user mirrors cycle/instret; without it those addresses are
// unimplemented.
// Ports:
//   clk    - pipeline clock, all state updates on the rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - csr_file_zicsr_if.slave: request in, csr_rdata/csr_illegal
//            (combinational), tohost/tohost_valid (registered) out
module csr_file_zicsr #(
  parameter int unsigned XLEN        = 32,
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [11:0] TOHOST_ADDR = 12'h51E
) (
  input  logic             clk,
  input  logic             rst_n,
  csr_file_zicsr_if.slave  bus
);

  localparam logic [1:0]  OP_RW = 2'b01;
  localparam logic [1:0]  OP_RS = 2'b10;
  localparam logic [1:0]  OP_RC = 2'b11;

  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MHARTID  = 12'hF14;
`ifdef CSR_COUNTERS_EN
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
`endif

  logic [XLEN-1:0] r_tohost;
  logic [XLEN-1:0] r_mscratch;
  logic            r_tohost_valid;
`ifdef CSR_COUNTERS_EN
  logic [63:0]     r_mcycle;
  logic [63:0]     r_minstret;
`else
  logic            w_unused_instret_inc;
  assign w_unused_instret_inc = bus.instret_inc;
`endif

  logic [XLEN-1:0] w_old;
  logic [XLEN-1:0] w_wval;
  logic            w_impl;
  logic            w_ro;
  logic            w_wr_attempt;
  logic            w_commit;

  // Address decode and pre-write read value
  always_comb begin
    w_old  = '0;
    w_impl = 1'b1;
    case (bus.csr_addr)
      TOHOST_ADDR: w_old = r_tohost;
      A_MSCRATCH:  w_old = r_mscratch;
      A_MHARTID:   w_old = XLEN'(HART_ID);
`ifdef CSR_COUNTERS_EN
      A_MCYCLE,    A_CYCLE:    w_old = r_mcycle[31:0];
      A_MCYCLEH,   A_CYCLEH:   w_old = r_mcycle[63:32];
      A_MINSTRET,  A_INSTRET:  w_old = r_minstret[31:0];
      A_MINSTRETH, A_INSTRETH: w_old = r_minstret[63:32];
`endif
      default:     w_impl = 1'b0;
    endcase
  end

  // Read-modify-write value
  always_comb begin
    w_wval = w_old;
    case (bus.csr_op)
      OP_RW:   w_wval = bus.csr_wsrc;
      OP_RS:   w_wval = w_old | bus.csr_wsrc;
      OP_RC:   w_wval = w_old & ~bus.csr_wsrc;
      default: w_wval = w_old;
    endcase
  end

  // RS/RC with a zero source are pure reads, so they are legal on read-only CSRs
  assign w_ro         = (bus.csr_addr[11:10] == 2'b11);
  assign w_wr_attempt = bus.csr_en &&
                        ((bus.csr_op == OP_RW) ||
                         (((bus.csr_op == OP_RS) || (bus.csr_op == OP_RC)) && !bus.csr_wsrc_zero));
  assign w_commit     = w_wr_attempt && w_impl && !w_ro;

  assign bus.csr_rdata    = w_old;
  assign bus.csr_illegal  = bus.csr_en && (!w_impl || (w_ro && w_wr_attempt));
  assign bus.tohost       = r_tohost;
  assign bus.tohost_valid = r_tohost_valid;

  // tohost, mscratch and the tohost write pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tohost       <= '0;
      r_mscratch     <= '0;
      r_tohost_valid <= 1'b0;
    end else begin
      r_tohost_valid <= w_commit && (bus.csr_addr == TOHOST_ADDR);
      if (w_commit && (bus.csr_addr == TOHOST_ADDR)) r_tohost   <= w_wval;
      if (w_commit && (bus.csr_addr == A_MSCRATCH))  r_mscratch <= w_wval;
    end
  end

`ifdef CSR_COUNTERS_EN
  // A write to either half suppresses that cycle's increment and carry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcycle <= '0;
    end else if (w_commit && (bus.csr_addr == A_MCYCLE)) begin
      r_mcycle[31:0] <= w_wval;
    end else if (w_commit && (bus.csr_addr == A_MCYCLEH)) begin
      r_mcycle[63:32] <= w_wval;
    end else begin
      r_mcycle <= r_mcycle + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_minstret <= '0;
    end else if (w_commit && (bus.csr_addr == A_MINSTRET)) begin
      r_minstret[31:0] <= w_wval;
    end else if (w_commit && (bus.csr_addr == A_MINSTRETH)) begin
      r_minstret[63:32] <= w_wval;
    end else if (bus.instret_inc) begin
      r_minstret <= r_minstret + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_csr_file_zicsr.sv
// Self-checking bench for csr_file_zicsr: CSR-level reference model checked
// every cycle, plus directed vectors with hand-computed literal expectations.
module tb_csr_file_zicsr;

  localparam logic [31:0] TB_HART   = 32'h0000_0003;
  localparam logic [11:0] TB_TOHOST = 12'h51E;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  csr_file_zicsr_if #(.XLEN(32)) bus ();

  csr_file_zicsr #(
    .XLEN(32), .HART_ID(TB_HART), .TOHOST_ADDR(TB_TOHOST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  logic [31:0] m_tohost   = '0;
  logic [31:0] m_mscratch = '0;
  logic        m_tv       = 1'b0;
  logic [63:0] m_mcycle   = '0;
  logic [63:0] m_minstret = '0;

  function automatic bit m_impl(input logic [11:0] a);
    if (a == TB_TOHOST || a == 12'h340 || a == 12'hF14) return 1'b1;
`ifdef CSR_COUNTERS_EN
    if (a == 12'hB00 || a == 12'hB80 || a == 12'hB02 || a == 12'hB82 ||
        a == 12'hC00 || a == 12'hC80 || a == 12'hC02 || a == 12'hC82) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_val(input logic [11:0] a);
    if (a == TB_TOHOST) return m_tohost;
    if (a == 12'h340)   return m_mscratch;
    if (a == 12'hF14)   return TB_HART;
`ifdef CSR_COUNTERS_EN
    if (a == 12'hB00 || a == 12'hC00) return m_mcycle[31:0];
    if (a == 12'hB80 || a == 12'hC80) return m_mcycle[63:32];
    if (a == 12'hB02 || a == 12'hC02) return m_minstret[31:0];
    if (a == 12'hB82 || a == 12'hC82) return m_minstret[63:32];
`endif
    return 32'h0;
  endfunction

  function automatic bit m_attempt();
    if (!bus.csr_en) return 1'b0;
    if (bus.csr_op == 2'b01) return 1'b1;
    if (bus.csr_op[1] && !bus.csr_wsrc_zero) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_ro(input logic [11:0] a);
    return a >= 12'hC00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Model update on each clock edge (or reset)
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_tohost = '0; m_mscratch = '0; m_tv = 1'b0; m_mcycle = '0; m_minstret = '0;
      end else begin
        logic [11:0] a;
        logic [31:0] old, wv;
        bit          cm;
        a   = bus.csr_addr;
        old = m_val(a);
        cm  = m_attempt() && m_impl(a) && !m_ro(a);
        case (bus.csr_op)
          2'b01:   wv = bus.csr_wsrc;
          2'b10:   wv = old | bus.csr_wsrc;
          default: wv = old & ~bus.csr_wsrc;
        endcase
        m_tv = cm && (a == TB_TOHOST);
        if (cm && a == TB_TOHOST) m_tohost = wv;
        if (cm && a == 12'h340)   m_mscratch = wv;
`ifdef CSR_COUNTERS_EN
        if (cm && a == 12'hB00)      m_mcycle = {m_mcycle[63:32], wv};
        else if (cm && a == 12'hB80) m_mcycle = {wv, m_mcycle[31:0]};
        else                         m_mcycle = m_mcycle + 64'd1;
        if (cm && a == 12'hB02)      m_minstret = {m_minstret[63:32], wv};
        else if (cm && a == 12'hB82) m_minstret = {wv, m_minstret[31:0]};
        else if (bus.instret_inc)    m_minstret = m_minstret + 64'd1;
`endif
      end
    end
  end

  // Every-cycle comparison against the model, mid low phase
  initial begin
    forever begin
      @(negedge clk);
      #2;
      chk("tohost", bus.tohost, m_tohost);
      chk("tohost_valid", 32'(bus.tohost_valid), 32'(m_tv));
      chk("csr_illegal", 32'(bus.csr_illegal),
          32'(bus.csr_en && (!m_impl(bus.csr_addr) || (m_ro(bus.csr_addr) && m_attempt()))));
      if (bus.csr_en) chk("csr_rdata", bus.csr_rdata, m_val(bus.csr_addr));
    end
  end

  task automatic cyc(input logic en, input logic [1:0] op, input logic [11:0] a,
                     input logic [31:0] ws, input logic wz, input logic inc);
    @(negedge clk);
    bus.csr_en = en; bus.csr_op = op; bus.csr_addr = a;
    bus.csr_wsrc = ws; bus.csr_wsrc_zero = wz; bus.instret_inc = inc;
  endtask

  task automatic idle();
    cyc(1'b0, 2'b00, 12'h000, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.csr_en = 1'b0; bus.csr_op = 2'b00; bus.csr_addr = '0;
    bus.csr_wsrc = '0; bus.csr_wsrc_zero = 1'b0; bus.instret_inc = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #3;
    chk("lit_reset_tohost", bus.tohost, 32'h0);
    chk("lit_reset_tv", 32'(bus.tohost_valid), 32'h0);

    // tohost write and one-cycle pulse
    cyc(1, 2'b01, 12'h51E, 32'h1, 0, 0); #3;
    chk("lit_tohost_rd0", bus.csr_rdata, 32'h0);
    idle(); #3;
    chk("lit_tohost_val", bus.tohost, 32'h1);
    chk("lit_tv_pulse", 32'(bus.tohost_valid), 32'h1);
    idle(); #3;
    chk("lit_tv_drop", 32'(bus.tohost_valid), 32'h0);

    // mscratch RMW chain
    cyc(1, 2'b01, 12'h340, 32'hA5A5_0000, 0, 0);
    cyc(1, 2'b10, 12'h340, 32'h0000_00FF, 0, 0); #3;
    chk("lit_ms_rs", bus.csr_rdata, 32'hA5A5_0000);
    cyc(1, 2'b11, 12'h340, 32'hA500_0000, 0, 0); #3;
    chk("lit_ms_rc", bus.csr_rdata, 32'hA5A5_00FF);
    cyc(1, 2'b10, 12'h340, 32'hFFFF_FFFF, 1, 0); #3;
    chk("lit_ms_final", bus.csr_rdata, 32'h00A5_00FF);
    cyc(1, 2'b00, 12'h340, 32'hFFFF_FFFF, 0, 0); #3;
    chk("lit_ms_unch", bus.csr_rdata, 32'h00A5_00FF);
    chk("lit_ms_notv", 32'(bus.tohost_valid), 32'h0);

    // mhartid read-only
    cyc(1, 2'b01, 12'hF14, 32'h0000_0123, 0, 0); #3;
    chk("lit_hart_ill", 32'(bus.csr_illegal), 32'h1);
    cyc(1, 2'b10, 12'hF14, 32'h0, 1, 0); #3;
    chk("lit_hart_rd", bus.csr_rdata, TB_HART);
    chk("lit_hart_rsz_legal", 32'(bus.csr_illegal), 32'h0);

    // Unimplemented address
    cyc(1, 2'b01, 12'h7C0, 32'h1234_5678, 0, 0); #3;
    chk("lit_unimpl_rd", bus.csr_rdata, 32'h0);
    chk("lit_unimpl_ill", 32'(bus.csr_illegal), 32'h1);
    cyc(0, 2'b01, 12'h7C0, 32'h1234_5678, 0, 0); #3;
    chk("lit_unimpl_noen", 32'(bus.csr_illegal), 32'h0);
    cyc(1, 2'b00, 12'h51E, 32'hDEAD_BEEF, 0, 0); #3;
    chk("lit_nop_ill", 32'(bus.csr_illegal), 32'h0);

    // Back-to-back tohost writes, same value still pulses
    cyc(1, 2'b01, 12'h51E, 32'h7, 0, 0);
    cyc(1, 2'b01, 12'h51E, 32'h7, 0, 0); #3;
    chk("lit_b2b_rd", bus.csr_rdata, 32'h7);
    cyc(1, 2'b10, 12'h51E, 32'h0, 1, 0); #3;
    chk("lit_same_tv", 32'(bus.tohost_valid), 32'h1);
    idle();

`ifdef CSR_COUNTERS_EN
    cyc(1, 2'b01, 12'hB00, 32'hFFFF_FFFE, 0, 0);
    idle(); idle(); idle();
    cyc(1, 2'b00, 12'hB00, 32'h0, 0, 0); #3;
    chk("lit_mcycle_lo", bus.csr_rdata, 32'h1);
    cyc(1, 2'b00, 12'hB80, 32'h0, 0, 0); #3;
    chk("lit_mcycle_hi", bus.csr_rdata, 32'h1);
    cyc(1, 2'b01, 12'hB02, 32'h5, 0, 1);
    cyc(1, 2'b00, 12'hC02, 32'h0, 0, 0); #3;
    chk("lit_minstret_wr_wins", bus.csr_rdata, 32'h5);
    cyc(1, 2'b01, 12'hB02, 32'hFFFF_FFFF, 0, 0);
    cyc(0, 2'b00, 12'h000, 32'h0, 0, 1);
    cyc(1, 2'b00, 12'hC82, 32'h0, 0, 0); #3;
    chk("lit_minstret_carry", bus.csr_rdata, 32'h1);
    cyc(1, 2'b01, 12'hB82, 32'h9, 0, 1);
    cyc(1, 2'b00, 12'hB02, 32'h0, 0, 0); #3;
    chk("lit_minstret_hold_lo", bus.csr_rdata, 32'h0);
    cyc(1, 2'b01, 12'hC00, 32'h0, 0, 0); #3;
    chk("lit_cycle_ro_ill", 32'(bus.csr_illegal), 32'h1);
`else
    cyc(1, 2'b01, 12'hB00, 32'h1, 0, 1); #3;
    chk("lit_nocnt_ill", 32'(bus.csr_illegal), 32'h1);
    chk("lit_nocnt_rd", bus.csr_rdata, 32'h0);
    cyc(1, 2'b00, 12'hC00, 32'h0, 0, 0); #3;
    chk("lit_nocnt_cycle", bus.csr_rdata, 32'h0);
`endif
    idle();

    // Async reset during a tohost write
    cyc(1, 2'b01, 12'h51E, 32'h9, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("lit_rst_tohost", bus.tohost, 32'h0);
    idle();
    rst_n = 1'b1;
    #3;
    chk("lit_rst_tv", 32'(bus.tohost_valid), 32'h0);
    idle(); #3;
    chk("lit_rst_tv2", 32'(bus.tohost_valid), 32'h0);
    chk("lit_rst_tohost2", bus.tohost, 32'h0);

    repeat (3) idle();
    #3;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/csr_file_zicsr.md
Name: csr_file_zicsr

Overview:
- Parametrised machine-mode CSR file for the three-stage RISC-V pipeline; replaces the single-port write-only CSR store.
- Executes Zicsr read-modify-write ops (RW/RS/RC, register or immediate source) in one cycle and returns the old CSR value for rd writeback.
- Holds tohost, mscratch and mhartid, with optional 64-bit cycle/instret counters.
- Flags illegal accesses to the pipeline.

Parameters:
- XLEN, 32, CSR data width; only 32 is supported.
- HART_ID, 0, constant value returned by mhartid (0xF14).
- TOHOST_ADDR, 12'h51E, address of the tohost register.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- csr_en  in  1  valid Zicsr instruction in the execute stage this cycle.
- csr_op  in  2  00 none, 01 RW, 10 RS (set bits), 11 RC (clear bits).
- csr_addr  in  12  CSR address.
- csr_wsrc  in  XLEN  rs1 value, or zimm zero-extended for immediate forms.
- csr_wsrc_zero  in  1  rs1 index or zimm is 0; suppresses the write for RS/RC.
- instret_inc  in  1  one instruction retired this cycle.
- csr_rdata  out  XLEN  old value of the addressed CSR; combinational.
- csr_illegal  out  1  combinational illegal-access flag.
- tohost  out  XLEN  current tohost contents.
- tohost_valid  out  1  one-cycle pulse after each tohost write.

Behaviour:
- Reset (async assert, sync release): tohost, mscratch and all counters go to 0; tohost_valid=0. csr_rdata and csr_illegal then follow their inputs combinationally.
- Read path:
  - csr_rdata is the pre-write value of csr_addr in the same cycle.
  - Unimplemented addresses read 0.
  - When csr_en=0, csr_rdata is don't-care; the bench compares it only while csr_en=1.
- Write value:
  - RW: wsrc.
  - RS: old | wsrc.
  - RC: old & ~wsrc.
  - Committed at the next rising edge. Latency: 1 cycle, so a back-to-back access to the same address reads the new value.
- Write attempt: csr_en=1 and (op=RW, or op in {RS,RC} with csr_wsrc_zero=0).
- Read-only addresses are those with addr[11:10]=2'b11 (mhartid, user counters).
  - A write attempt to one sets csr_illegal=1 and leaves state unchanged.
  - RS/RC with csr_wsrc_zero=1 to a read-only address is legal.
- An unimplemented address with csr_en=1 sets csr_illegal=1, with no state change.
- csr_op=00 with csr_en=1 is a no-op: no write, csr_illegal=0.
- tohost_valid=1 for exactly one cycle after any committed tohost write, including one that writes the same value.
- csr_en=0: no state change except counter increments; csr_illegal=0.
- Reset mid-operation: a pending write is discarded; tohost_valid is forced to 0.

Optional Feature:
- Macro: CSR_COUNTERS_EN.
- Defined:
  - 64-bit mcycle increments every cycle out of reset.
  - 64-bit minstret increments when instret_inc=1.
  - Addresses:
    - mcycle: 0xB00 low, 0xB80 high, RW.
    - minstret: 0xB02 low, 0xB82 high, RW.
    - cycle/cycleh: 0xC00/0xC80, RO mirrors of mcycle.
    - instret/instreth: 0xC02/0xC82, RO mirrors of minstret.
  - A CSR write to one half in the same cycle as an increment:
    - the written half takes the new value;
    - the other half holds its value (no increment, no carry that cycle);
    - the write wins.
  - Low-word overflow carries into the high word; the full 64-bit counter wraps to 0.
- Undefined:
  - No counter logic.
  - All counter addresses are unimplemented: they read 0 and set csr_illegal when csr_en=1.
  - instret_inc is ignored.

Test Plan:
- Reset, then RW 0x51E wsrc=0x0000_0001 → csr_rdata=0. Next cycle: tohost=1, tohost_valid=1 for exactly one cycle.
- mscratch: RW 0xA5A5_0000, then RS 0x0000_00FF (rdata 0xA5A5_0000), then RC 0xA500_0000 (rdata 0xA5A5_00FF) → final read 0x00A5_00FF.
- RS to 0x340 with csr_wsrc_zero=1 and wsrc=0xFFFF_FFFF → value unchanged, no tohost_valid. RW to 0xF14 → csr_illegal=1, mhartid still reads HART_ID.
- Unimplemented 0x7C0, csr_en=1 → csr_rdata=0, csr_illegal=1. Same access with csr_en=0 → csr_illegal=0.
- CSR_COUNTERS_EN:
  - RW 0xB00=0xFFFF_FFFE then idle 3 cycles → mcycle reads 0x1 with mcycleh=0x1.
  - Write 0xB02=5 with instret_inc=1 in the same cycle → minstret=5.
- Assert rst_n low asynchronously in the same cycle as an RW to tohost → tohost=0 and no tohost_valid pulse after release.
